// File: rtl/vgpr_wr_pkg.sv
// Shared constants for the VGPR write-port arbiter and write mux.
// Also holds the source-to-port index map and a one-hot-to-index helper.
package vgpr_wr_pkg;

    localparam int VGPR_NUM_WR_PORTS = 8;
    localparam int VGPR_WR_SEL_W     = 16;
    localparam int VGPR_STARVE_W     = 4;
    localparam int VGPR_STARVE_LIMIT = 12;
    localparam int VGPR_PTR_W        = 3;

    // Write-source slot on the arbiter; the mux instantiation uses the same map.
    localparam int WR_SRC_SIMD0  = 0;
    localparam int WR_SRC_SIMD1  = 1;
    localparam int WR_SRC_SIMD2  = 2;
    localparam int WR_SRC_SIMD3  = 3;
    localparam int WR_SRC_SIMF0  = 4;
    localparam int WR_SRC_SIMF1  = 5;
    localparam int WR_SRC_LSU_LO = 6;
    localparam int WR_SRC_LSU_HI = 7;

    function automatic logic [VGPR_PTR_W-1:0] onehot_to_idx(input logic [VGPR_NUM_WR_PORTS-1:0] oh);
        logic [VGPR_PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < VGPR_NUM_WR_PORTS; i++) begin
            if (oh[i]) idx = idx | VGPR_PTR_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/vgpr_wr_port_arbiter_if.sv
// Request/grant/select bundle between the write sources and the write-port arbiter.
interface vgpr_wr_port_arbiter_if;
    import vgpr_wr_pkg::*;

    logic [VGPR_NUM_WR_PORTS-1:0] port_wr_req;
    logic                         bank_stall;
    logic [VGPR_NUM_WR_PORTS-1:0] port_wr_grant;
    logic [VGPR_WR_SEL_W-1:0]     wr_port_select;
    logic                         wr_select_valid;
    logic                         urgent_active;

    modport master (
        output port_wr_req,
        output bank_stall,
        input  port_wr_grant,
        input  wr_port_select,
        input  wr_select_valid,
        input  urgent_active
    );

    modport slave (
        input  port_wr_req,
        input  bank_stall,
        output port_wr_grant,
        output wr_port_select,
        output wr_select_valid,
        output urgent_active
    );

endinterface

// File: rtl/wr_arb_rr_pick.sv
// Rotating-priority encoder: first set request at or after ptr, wrapping 7->0.
module wr_arb_rr_pick
    import vgpr_wr_pkg::*;
(
    input  logic [VGPR_NUM_WR_PORTS-1:0] req,
    input  logic [VGPR_PTR_W-1:0]        ptr,
    output logic [VGPR_NUM_WR_PORTS-1:0] gnt,
    output logic                         any
);

    logic [VGPR_PTR_W-1:0] idx;

    always_comb begin
        gnt = '0;
        any = 1'b0;
        idx = '0;
        for (int k = 0; k < VGPR_NUM_WR_PORTS; k++) begin
            idx = ptr + VGPR_PTR_W'(k);
            if (!any && req[idx]) begin
                gnt[idx] = 1'b1;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vgpr_wr_port_arbiter.sv
// Round-robin VGPR write-port arbiter with starvation escalation and bank-stall backpressure.
// Produces a registered one-hot grant and the matching registered mux select.
module vgpr_wr_port_arbiter
    import vgpr_wr_pkg::*;
#(
    parameter int NUM_PORTS    = VGPR_NUM_WR_PORTS,
    parameter int SEL_W        = VGPR_WR_SEL_W,
    parameter int STARVE_W     = VGPR_STARVE_W,
    parameter int STARVE_LIMIT = VGPR_STARVE_LIMIT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    vgpr_wr_port_arbiter_if.slave  wr
);

    localparam logic [STARVE_W-1:0] LIMIT_V = STARVE_W'(STARVE_LIMIT);
    localparam logic [STARVE_W-1:0] CNT_MAX = '1;

    logic [NUM_PORTS-1:0]  grant_q;
    logic [SEL_W-1:0]      sel_q;
    logic                  valid_q;
    logic                  urgent_q;
    logic [VGPR_PTR_W-1:0] rr_ptr;
    logic [STARVE_W-1:0]   starve_cnt [NUM_PORTS];

    logic [NUM_PORTS-1:0]  eff_req;
    logic [NUM_PORTS-1:0]  urgent_req;
    logic [NUM_PORTS-1:0]  urg_gnt;
    logic [NUM_PORTS-1:0]  norm_gnt;
    logic                  urg_any;
    logic                  norm_any;
    logic [NUM_PORTS-1:0]  next_grant;
    logic                  next_urgent;

    // A port being granted this cycle is masked so it cannot win again in the same cycle.
    always_comb begin
        eff_req = wr.port_wr_req & ~grant_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            urgent_req[i] = eff_req[i] && (starve_cnt[i] >= LIMIT_V);
        end
    end

    wr_arb_rr_pick u_pick_urgent (
        .req (urgent_req),
        .ptr (rr_ptr),
        .gnt (urg_gnt),
        .any (urg_any)
    );

    wr_arb_rr_pick u_pick_normal (
        .req (eff_req),
        .ptr (rr_ptr),
        .gnt (norm_gnt),
        .any (norm_any)
    );

    always_comb begin
        next_grant  = '0;
        next_urgent = 1'b0;
        if (!wr.bank_stall && norm_any) begin
            if (urg_any) begin
                next_grant  = urg_gnt;
                next_urgent = 1'b1;
            end else begin
                next_grant  = norm_gnt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q  <= '0;
            sel_q    <= '0;
            valid_q  <= 1'b0;
            urgent_q <= 1'b0;
            rr_ptr   <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                starve_cnt[i] <= '0;
            end
        end else begin
            grant_q  <= next_grant;
            sel_q    <= SEL_W'(next_grant);
            valid_q  <= |next_grant;
            urgent_q <= next_urgent;
            if (|next_grant) begin
                rr_ptr <= onehot_to_idx(next_grant) + VGPR_PTR_W'(1);
            end
            // Waiting ports keep aging through a bank stall so they escalate afterwards.
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (next_grant[i] || !wr.port_wr_req[i]) begin
                    starve_cnt[i] <= '0;
                end else if (eff_req[i] && (starve_cnt[i] != CNT_MAX)) begin
                    starve_cnt[i] <= starve_cnt[i] + STARVE_W'(1);
                end
            end
        end
    end

    assign wr.port_wr_grant   = grant_q;
    assign wr.wr_port_select  = sel_q;
    assign wr.wr_select_valid = valid_q;
    assign wr.urgent_active   = urgent_q;

endmodule

// File: tb/tb_vgpr_wr_port_arbiter.sv
// Directed bench for vgpr_wr_port_arbiter: reset, round-robin, streaming, stall, starvation, async reset.
module tb_vgpr_wr_port_arbiter;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    vgpr_wr_port_arbiter_if wr_if ();

    vgpr_wr_port_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (wr_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] g, input logic u);
        chk({tag, ".grant"},  32'(wr_if.port_wr_grant),   32'(g));
        chk({tag, ".select"}, 32'(wr_if.wr_port_select),  32'({8'h00, g}));
        chk({tag, ".valid"},  32'(wr_if.wr_select_valid), 32'(|g));
        chk({tag, ".urgent"}, 32'(wr_if.urgent_active),   32'(u));
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        wr_if.port_wr_req = 8'hFF;
        wr_if.bank_stall  = 1'b0;

        // 1: reset holds everything at zero even with all ports requesting
        repeat (3) begin
            tick();
            chk_out("reset_hold", 8'h00, 1'b0);
        end
        rst_n = 1'b1;
        tick();
        chk_out("first_grant", 8'h01, 1'b0);

        // 2: full round-robin with all ports requesting
        for (int k = 1; k < 8; k++) begin
            tick();
            chk_out("rr_sweep", 8'(1 << k), 1'b0);
        end
        tick();
        chk_out("rr_wrap", 8'h01, 1'b0);

        // 3: lone streaming port is granted every other cycle
        wr_if.port_wr_req = 8'h00;
        tick();
        chk_out("idle", 8'h00, 1'b0);
        wr_if.port_wr_req = 8'h08;
        tick(); chk_out("stream_a", 8'h08, 1'b0);
        tick(); chk_out("stream_b", 8'h00, 1'b0);
        tick(); chk_out("stream_c", 8'h08, 1'b0);
        tick(); chk_out("stream_d", 8'h00, 1'b0);
        wr_if.port_wr_req = 8'h00;
        tick();
        chk("ptr_after_stream", 32'(dut.rr_ptr), 32'd4);

        // 4: stall blocks grants and freezes rr_ptr; release wraps from ptr=4 to port 0
        wr_if.port_wr_req = 8'h05;
        wr_if.bank_stall  = 1'b1;
        repeat (5) begin
            tick();
            chk_out("stall", 8'h00, 1'b0);
        end
        chk("ptr_in_stall", 32'(dut.rr_ptr), 32'd4);
        chk("cnt2_in_stall", 32'(dut.starve_cnt[2]), 32'd5);
        wr_if.bank_stall = 1'b0;
        tick();
        chk_out("stall_release", 8'h01, 1'b0);
        wr_if.port_wr_req = 8'h00;
        tick();
        chk_out("idle2", 8'h00, 1'b0);

        // 5: port 7 ages under stall; at 11 it is still normal, at 12 it goes urgent
        wr_if.port_wr_req = 8'h80;
        wr_if.bank_stall  = 1'b1;
        repeat (11) tick();
        chk("cnt7_pre", 32'(dut.starve_cnt[7]), 32'd11);
        wr_if.port_wr_req = 8'hFF;
        wr_if.bank_stall  = 1'b0;
        tick();
        chk_out("below_limit", 8'h02, 1'b0);
        tick();
        chk_out("urgent_win", 8'h80, 1'b1);
        tick();
        chk_out("after_urgent", 8'h01, 1'b0);
        tick(); chk_out("to_10_a", 8'h02, 1'b0);
        tick(); chk_out("to_10_b", 8'h04, 1'b0);
        tick(); chk_out("to_10_c", 8'h08, 1'b0);
        tick(); chk_out("to_10_d", 8'h10, 1'b0);

        // 6: async reset between edges kills the grant at once
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_reset", 8'h00, 1'b0);
        chk("ptr_reset", 32'(dut.rr_ptr), 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk("cnt_reset", 32'(dut.starve_cnt[i]), 32'd0);
        end
        wr_if.port_wr_req = 8'h00;
        #3;
        rst_n = 1'b1;
        tick();
        chk_out("post_reset_idle", 8'h00, 1'b0);

        // counter saturation, then an urgent grant out of saturation
        wr_if.port_wr_req = 8'h01;
        wr_if.bank_stall  = 1'b1;
        repeat (20) tick();
        chk("cnt0_saturate", 32'(dut.starve_cnt[0]), 32'd15);
        chk_out("sat_stalled", 8'h00, 1'b0);
        wr_if.bank_stall = 1'b0;
        tick();
        chk_out("sat_urgent", 8'h01, 1'b1);
        chk("cnt0_cleared", 32'(dut.starve_cnt[0]), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vgpr_wr_port_arbiter.md
Name: vgpr_wr_port_arbiter

Overview:
Upstream stage of the VGPR write-port mux. It arbitrates among 8 VGPR write sources (SIMD/SIMF ALUs, LSU returns, etc.) and produces the registered one-hot 16-bit wr_port_select that steers the mux. It returns a one-cycle grant to the winning port. Arbitration is round-robin with starvation escalation, and the block honours a bank-stall backpressure input.

Parameters:
NUM_PORTS, 8, number of write requesters; only 8 is supported.
SEL_W, 16, width of wr_port_select; bits [SEL_W-1:NUM_PORTS] are always 0.
STARVE_W, 4, width of each per-port starvation counter.
STARVE_LIMIT, 12, wait count (in cycles) at which a requester becomes urgent; must be < 2^STARVE_W.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
port_wr_req  input  NUM_PORTS  bit i: port i has write data/addr/mask/en valid on its mux inputs
bank_stall  input  1  VGPR bank cannot accept a write this cycle
port_wr_grant  output  NUM_PORTS  one-hot (or 0) grant, registered; port i's write is taken in the cycle this is high
wr_port_select  output  SEL_W  registered one-hot select to the write mux; equals {8'b0, port_wr_grant}
wr_select_valid  output  1  registered; equals |port_wr_grant
urgent_active  output  1  registered; high in the cycle the current grant came from the urgent class

Behaviour:
- Reset (async, rst_n=0): port_wr_grant=0, wr_port_select=0, wr_select_valid=0, urgent_active=0, rr_ptr=0, all starvation counters=0. Assertion mid-grant kills the grant immediately. No write is issued until the first edge after rst_n rises.
- Effective request in cycle t: eff_req = port_wr_req & ~port_wr_grant. A port granted in cycle t cannot win the arbitration evaluated in cycle t.
- Latency: a request sampled at the edge ending cycle t produces a grant in cycle t+1. The port must hold req and its write payload stable until it sees grant. In the grant cycle the mux routes that port. The port drops req (or presents the next write) in the cycle after grant.
- Winner selection (evaluated combinationally in cycle t, registered at the edge):
  - If bank_stall=1 or eff_req=0: next grant = 0, next select = 0, next urgent_active = 0.
  - Else if any port has eff_req with counter >= STARVE_LIMIT (urgent class): pick among the urgent ports by a round-robin search starting at rr_ptr, wrapping 7->0. Next urgent_active = 1.
  - Else: pick among eff_req by a round-robin search starting at rr_ptr, wrapping. Next urgent_active = 0.
- rr_ptr: on a grant to port w, rr_ptr <= (w+1) mod 8. Otherwise rr_ptr holds, including during stall.
- Starvation counter i, per edge:
  - Clear if port i is granted next cycle, or if port_wr_req[i]=0.
  - Else increment if eff_req[i]=1 and port i did not win; saturate at 2^STARVE_W-1.
  - Counters keep incrementing during bank_stall.
- Throughput: at most one grant per cycle. A lone port streaming requests is granted every other cycle (masking rule). Two or more competing ports allow back-to-back grants.
- Invariants: port_wr_grant is one-hot or zero, and wr_port_select[15:8] = 0 always. Grant to port i implies port_wr_req[i] was high at the sampling edge.
- Simultaneous stall and all-request: no grant; all requesting counters advance.
- Request dropped before grant (illegal by protocol): the counter clears and no grant is issued.

Decomposition:
- Shared package vgpr_wr_pkg holds:
  - VGPR_NUM_WR_PORTS=8, VGPR_WR_SEL_W=16, VGPR_STARVE_LIMIT=12.
  - Port index constants for each write source, shared with the mux instantiation.
- One sub-module, wr_arb_rr_pick: combinational rotate-priority encoder.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: one-hot gnt[7:0], any.
  - Instantiated twice: urgent class and normal class.

Test Plan:
1. Reset: hold rst_n=0 with port_wr_req=8'hFF. All outputs stay 0. Release rst_n: in the next cycle grant=8'h01 and select=16'h0001.
2. Round-robin: port_wr_req=8'hFF constant, no stall. Grants go 01,02,04,...,80,01 on consecutive cycles, with wr_select_valid=1 every cycle.
3. Single port streaming: port_wr_req=8'h08 held. Grant toggles 08,00,08,00, and select alternates 16'h0008 / 16'h0000.
4. Stall: 8'h05 requesting with bank_stall=1 for 5 cycles. Grant stays 0 and rr_ptr is unchanged. Stall drops and the grant goes to the port next after rr_ptr.
5. Starvation: hold port 7 req with heavy traffic on ports 0-6 and rr_ptr forced away (directed via stall pattern). Once port 7's counter hits 12, the next grant is 8'h80 with urgent_active=1.
6. Async reset mid-grant: assert rst_n=0 between edges while grant=8'h10. Outputs clear immediately, and rr_ptr and counters read 0 after release.
